// File: rtl/psum_add_tree.sv
// ----------------------------------------------------------------------------
// psum_add_tree : registered signed adder tree with multi-pass psum accumulator
// Revision      : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module psum_add_tree #(
   parameter int DWIDTH    = 32,
   parameter int PE_DWIDTH = 16,
   parameter int NUM_PE    = 9,
   parameter bit SAT_EN    = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [NUM_PE*PE_DWIDTH-1:0]   pe_data,
   input  logic [DWIDTH-1:0]             psum_in,
   input  logic [7:0]                    acc_len,
   input  logic                          clr,
   output logic                          out_valid,
   output logic [DWIDTH-1:0]             psum_out,
   output logic                          ovf,
   output logic                          busy
);

   localparam int LEVELS = $clog2(NUM_PE);

   function automatic int lvl_n(input int l);
      return (NUM_PE + (1 << l) - 1) >> l;
   endfunction

   // Bit offset of level l inside the flattened {tree levels, leaves} vector.
   function automatic int lvl_off(input int l);
      int s;
      s = 0;
      for (int k = 0; k < l; k++) s += lvl_n(k) * DWIDTH;
      return s;
   endfunction

   localparam int LEAF_W = NUM_PE * DWIDTH;
   localparam int ALL_W  = lvl_off(LEVELS + 1);
   localparam int TREE_W = ALL_W - LEAF_W;
   localparam int ROOT   = lvl_off(LEVELS);

   localparam logic [DWIDTH-1:0] c_sat_max = {1'b0, {(DWIDTH-1){1'b1}}};
   localparam logic [DWIDTH-1:0] c_sat_min = {1'b1, {(DWIDTH-1){1'b0}}};

   logic [LEAF_W-1:0]  w_leaf;
   logic [TREE_W-1:0]  w_tree_nxt;
   logic [TREE_W-1:0]  r_tree;
   logic [ALL_W-1:0]   w_all;

   logic [LEVELS-1:0]  r_vld;
   logic [DWIDTH-1:0]  r_psum_d [LEVELS];
   logic [7:0]         r_len_d  [LEVELS];

   logic [7:0]         r_cnt;
   logic [7:0]         r_len;
   logic [DWIDTH-1:0]  r_acc;
   logic [DWIDTH-1:0]  r_psum_out;
   logic               r_out_valid;
   logic               r_ovf;

   logic               w_beat;
   logic               w_first;
   logic               w_close;
   logic               w_ovf;
   logic [7:0]         w_len;
   logic [DWIDTH-1:0]  w_base;
   logic [DWIDTH-1:0]  w_tree_sum;
   logic [DWIDTH:0]    w_sum_ext;
   logic [DWIDTH-1:0]  w_acc_nxt;

   for (genvar i = 0; i < NUM_PE; i++) begin : g_leaf
      assign w_leaf[i*DWIDTH +: DWIDTH] =
         {{(DWIDTH-PE_DWIDTH){pe_data[(i+1)*PE_DWIDTH-1]}}, pe_data[i*PE_DWIDTH +: PE_DWIDTH]};
   end

   assign w_all = {r_tree, w_leaf};

   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int N_IN  = lvl_n(l - 1);
      localparam int N_OUT = lvl_n(l);
      localparam int SRC   = lvl_off(l - 1);
      localparam int DST   = lvl_off(l) - LEAF_W;
      for (genvar j = 0; j < N_OUT; j++) begin : g_node
         if (2*j + 1 < N_IN) begin : g_pair
            assign w_tree_nxt[DST + j*DWIDTH +: DWIDTH] =
               w_all[SRC + 2*j*DWIDTH +: DWIDTH] + w_all[SRC + (2*j+1)*DWIDTH +: DWIDTH];
         end else begin : g_pass
            assign w_tree_nxt[DST + j*DWIDTH +: DWIDTH] = w_all[SRC + 2*j*DWIDTH +: DWIDTH];
         end
      end
   end

   assign w_tree_sum = w_all[ROOT +: DWIDTH];

   // Tree data is left running on clr; only the valid bits decide what counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tree <= '0;
         r_vld  <= '0;
         for (int k = 0; k < LEVELS; k++) begin
            r_psum_d[k] <= '0;
            r_len_d[k]  <= '0;
         end
      end else begin
         r_tree      <= w_tree_nxt;
         r_vld[0]    <= in_valid & ~clr;
         r_psum_d[0] <= psum_in;
         r_len_d[0]  <= acc_len;
         for (int k = 1; k < LEVELS; k++) begin
            r_vld[k]    <= r_vld[k-1] & ~clr;
            r_psum_d[k] <= r_psum_d[k-1];
            r_len_d[k]  <= r_len_d[k-1];
         end
      end
   end

   assign w_beat  = r_vld[LEVELS-1];
   assign w_first = (r_cnt == 8'd0);
   assign w_len   = w_first ? ((r_len_d[LEVELS-1] == 8'd0) ? 8'd1 : r_len_d[LEVELS-1]) : r_len;
   assign w_base  = w_first ? r_psum_d[LEVELS-1] : r_acc;
   assign w_close = (r_cnt == w_len - 8'd1);

   assign w_sum_ext = {w_base[DWIDTH-1], w_base} + {w_tree_sum[DWIDTH-1], w_tree_sum};
   assign w_ovf     = w_sum_ext[DWIDTH] ^ w_sum_ext[DWIDTH-1];

   always_comb begin
      w_acc_nxt = w_sum_ext[DWIDTH-1:0];
      if (SAT_EN && w_ovf) w_acc_nxt = w_sum_ext[DWIDTH] ? c_sat_min : c_sat_max;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt       <= '0;
         r_len       <= '0;
         r_acc       <= '0;
         r_psum_out  <= '0;
         r_out_valid <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (clr) begin
         r_cnt       <= '0;
         r_len       <= '0;
         r_acc       <= '0;
         r_psum_out  <= '0;
         r_out_valid <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (w_beat) begin
            r_acc <= w_acc_nxt;
            if (w_ovf) r_ovf <= 1'b1;
            if (w_first) r_len <= w_len;
            if (w_close) begin
               r_out_valid <= 1'b1;
               r_psum_out  <= w_acc_nxt;
               r_cnt       <= 8'd0;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign psum_out  = r_psum_out;
   assign ovf       = r_ovf;
   assign busy      = (|r_vld) | (r_cnt != 8'd0);

endmodule

`default_nettype wire

// File: tb/tb_psum_add_tree.sv
// ----------------------------------------------------------------------------
// tb_psum_add_tree : directed self-checking bench, saturating and wrapping DUTs
// Revision         : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_psum_add_tree;

   localparam int DW  = 32;
   localparam int PW  = 16;
   localparam int NPE = 9;

   logic              clk = 1'b0;
   logic              rst;
   logic              clr;
   logic              in_valid;
   logic [NPE*PW-1:0] pe_data;
   logic [DW-1:0]     psum_in;
   logic [7:0]        acc_len;

   logic              out_valid,   out_valid_w;
   logic [DW-1:0]     psum_out,    psum_out_w;
   logic              ovf,         ovf_w;
   logic              busy,        busy_w;

   psum_add_tree #(.DWIDTH(DW), .PE_DWIDTH(PW), .NUM_PE(NPE), .SAT_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pe_data(pe_data), .psum_in(psum_in),
      .acc_len(acc_len), .clr(clr), .out_valid(out_valid), .psum_out(psum_out),
      .ovf(ovf), .busy(busy)
   );

   psum_add_tree #(.DWIDTH(DW), .PE_DWIDTH(PW), .NUM_PE(NPE), .SAT_EN(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pe_data(pe_data), .psum_in(psum_in),
      .acc_len(acc_len), .clr(clr), .out_valid(out_valid_w), .psum_out(psum_out_w),
      .ovf(ovf_w), .busy(busy_w)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          c;
      logic [31:0] v;
      logic [31:0] vw;
      logic        vld_w;
   } ev_t;

   ev_t q[$];

   always @(negedge clk) begin
      if (out_valid) begin
         ev_t e;
         e.c     = cyc;
         e.v     = psum_out;
         e.vw    = psum_out_w;
         e.vld_w = out_valid_w;
         q.push_back(e);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [15:0] pe, input logic [31:0] ps, input logic [7:0] len,
                       output int c);
      in_valid = 1'b1;
      pe_data  = {NPE{pe}};
      psum_in  = ps;
      acc_len  = len;
      c        = cyc;
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input int idx, input int c, input logic [31:0] v);
      if (q.size() > idx) begin
         check({tag, "_cyc"}, q[idx].c, c);
         check({tag, "_val"}, q[idx].v, v);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0, c1, c2;
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; pe_data = '0; psum_in = '0; acc_len = '0;
      tick(3);
      check("rst_psum_out", psum_out, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      tick(2);

      // single beat: 9*1 + 100
      q.delete();
      send(16'd1, 32'd100, 8'd1, c0);
      tick(3);
      check("t1_busy_hi", busy, 1);
      tick(2);
      check("t1_busy_lo", busy, 0);
      tick(4);
      check("t1_count", q.size(), 1);
      expect_out("t1", 0, c0 + 5, 32'd109);

      // three beats back to back, later psum_in and acc_len ignored: 10 - 54
      q.delete();
      send(16'hFFFE, 32'd10, 8'd3, c0);
      send(16'hFFFE, 32'd999, 8'd1, c1);
      send(16'hFFFE, 32'd999, 8'd1, c2);
      tick(8);
      check("t2_count", q.size(), 1);
      expect_out("t2", 0, c2 + 5, 32'hFFFF_FFD4);
      check("t2_hold", psum_out, 32'hFFFF_FFD4);

      // gapped group followed immediately by a single-beat group
      q.delete();
      send(16'hFFFE, 32'd10, 8'd3, c0);
      tick(2);
      send(16'hFFFE, 32'd999, 8'd3, c0);
      tick(2);
      send(16'hFFFE, 32'd999, 8'd3, c1);
      send(16'd0, 32'd7, 8'd1, c2);
      tick(8);
      check("t3_count", q.size(), 2);
      expect_out("t3a", 0, c1 + 5, 32'hFFFF_FFD4);
      expect_out("t3b", 1, c2 + 5, 32'd7);

      // overflow: saturate vs wrap, then sticky flag
      q.delete();
      send(16'd16, 32'h7FFF_FFF0, 8'd1, c0);
      tick(8);
      check("t4_count", q.size(), 1);
      expect_out("t4_sat", 0, c0 + 5, 32'h7FFF_FFFF);
      if (q.size() > 0) begin
         check("t4_wrap_val", q[0].vw, 32'h8000_0080);
         check("t4_wrap_vld", q[0].vld_w, 1);
      end
      check("t4_ovf", ovf, 1);
      check("t4_ovf_wrap", ovf_w, 1);
      send(16'd1, 32'd100, 8'd1, c1);
      tick(8);
      check("t4_ovf_sticky", ovf, 1);
      check("t4_count2", q.size(), 2);
      expect_out("t4b", 1, c1 + 5, 32'd109);

      // acc_len = 0 behaves as 1, twice in a row
      q.delete();
      send(16'd3, 32'd0, 8'd0, c0);
      send(16'd3, 32'd0, 8'd0, c1);
      tick(8);
      check("t5_count", q.size(), 2);
      expect_out("t5a", 0, c0 + 5, 32'd27);
      expect_out("t5b", 1, c1 + 5, 32'd27);

      // asynchronous reset in the middle of an open group
      q.delete();
      send(16'd1, 32'd0, 8'd4, c0);
      send(16'd1, 32'd0, 8'd4, c0);
      tick(1);
      #2 rst = 1'b1;
      #1;
      check("t6_psum_out", psum_out, 0);
      check("t6_ovf", ovf, 0);
      check("t6_busy", busy, 0);
      check("t6_out_valid", out_valid, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick(8);
      check("t6_no_out", q.size(), 0);
      send(16'd2, 32'd5, 8'd1, c0);
      tick(8);
      check("t6_count", q.size(), 1);
      expect_out("t6", 0, c0 + 5, 32'd23);

      // synchronous clear with a coincident beat, then a beat right after
      send(16'd16, 32'h7FFF_FFF0, 8'd1, c0);
      tick(8);
      check("t7_ovf_pre", ovf, 1);
      q.delete();
      send(16'd1, 32'd0, 8'd4, c0);
      send(16'd1, 32'd0, 8'd4, c0);
      clr = 1'b1;
      in_valid = 1'b1; pe_data = {NPE{16'd5}}; psum_in = 32'd1000; acc_len = 8'd1;
      tick(1);
      clr = 1'b0;
      in_valid = 1'b0;
      check("t7_psum_out", psum_out, 0);
      check("t7_ovf", ovf, 0);
      check("t7_busy", busy, 0);
      send(16'd2, 32'd5, 8'd1, c0);
      tick(8);
      check("t7_count", q.size(), 1);
      expect_out("t7", 0, c0 + 5, 32'd23);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/psum_add_tree.md
# psum_add_tree

Parametrised partial-sum reducer for the conv kernel datapath. It sums NUM_PE signed PE products through a registered adder tree and adds an incoming upstream partial sum. It can accumulate the result over a programmable number of passes, for input-channel tiling, before emitting one output. It sits between the PE array and the next psum stage or the output buffer.

## Interface
- DWIDTH, 32, psum/accumulator width; must satisfy DWIDTH >= PE_DWIDTH + LEVELS
- PE_DWIDTH, 16, width of each signed PE product
- NUM_PE, 9, number of PE products reduced per beat (>= 2)
- SAT_EN, 1, 1: saturate the accumulator on overflow; 0: two's-complement wrap
- Derived: LEVELS = ceil(log2(NUM_PE)) (4 for NUM_PE=9)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat qualifier for pe_data/psum_in
- pe_data  in  NUM_PE*PE_DWIDTH  packed signed products, PE i at bits [i*PE_DWIDTH +: PE_DWIDTH]
- psum_in  in  DWIDTH  signed upstream partial sum; used only on the first beat of a group
- acc_len  in  8  beats per output group; 0 is treated as 1; sampled on the first beat of a group
- clr  in  1  synchronous clear, same effect as rst
- out_valid  out  1  one-cycle pulse, psum_out valid
- psum_out  out  DWIDTH  signed group result, held until the next out_valid
- ovf  out  1  sticky overflow flag
- busy  out  1  high while any beat is in the tree or a group is open

## Operation
- Leaves: each product is sign-extended to DWIDTH. Pairwise adds run per level, one register stage per level. An odd element at a level passes through registered. No overflow is possible inside the tree, given the width rule.
- psum_in and in_valid are delayed LEVELS cycles in step with the tree.
- Accumulator stage, one register, acts on each valid beat leaving the tree:
  - First beat of a group (cnt == 0): acc = psum_in_d + tree_sum. Latch len = max(acc_len sampled at input, 1); acc_len travels with the beat.
  - Later beats: acc = acc + tree_sum. psum_in is ignored.
  - The add is done at DWIDTH+1 bits. On overflow: if SAT_EN, clamp to +2^(DWIDTH-1)-1 or -2^(DWIDTH-1); otherwise wrap. ovf is set in both cases.
  - If cnt == len-1: out_valid=1, psum_out = new acc value, cnt goes to 0. Otherwise cnt = cnt+1.
- Gaps in in_valid are allowed anywhere, including mid-group. The counter advances only on valid beats.
- busy = any delay-line valid bit set OR cnt != 0.
- ovf clears only on rst or clr.

## Timing
- Latency: a beat accepted at cycle T, if it closes a group, gives out_valid at T+LEVELS+1 (T+5 for NUM_PE=9).
- Throughput: one beat per cycle. There is no backpressure; the consumer must accept every out_valid.
- Reset values:
  - psum_out = 0, out_valid = 0, ovf = 0, busy = 0
  - cnt = 0, acc = 0, all pipeline valid bits = 0
- rst or clr mid-operation: in-flight beats and the open group are discarded. No out_valid is produced for them.
- in_valid in the same cycle as clr: clr wins and the beat is dropped.
- in_valid in the cycle after clr is deasserted: the beat is accepted normally.
- Back-to-back groups: the first beat of the next group may follow the closing beat directly. Its psum_in is used and acc restarts; there is no bubble.
- acc_len changed mid-group has no effect until the next group starts.

## Test plan
- Single beat, acc_len=1, NUM_PE=9, all PE = 1, psum_in = 100, at T=0 -> out_valid at T=5 with psum_out = 109; busy low from T=6.
- acc_len=3, three consecutive beats with all PE = -2 and psum_in = 10 (10 on beat 0, 999 on beats 1–2) -> one out_valid only, on the third beat's exit, psum_out = 10 - 54 = -44; psum_in of later beats ignored.
- Same group of 3 with 2-cycle gaps between beats, then an immediate second group (acc_len=1, PE=0, psum_in=7) -> outputs -44 then 7, on consecutive valid-beat exits.
- SAT_EN=1, psum_in = 0x7FFF_FFF0, all PE = 16 -> psum_out = 0x7FFF_FFFF, ovf = 1 and sticky. SAT_EN=0, same stimulus -> psum_out = 0x8000_0080, ovf = 1.
- acc_len=0, PE = 3, psum_in = 0 -> treated as 1, psum_out = 27.
- Open group (acc_len=4, two beats sent), then rst pulsed asynchronously mid-cycle -> outputs zero immediately with no out_valid. Then a new group (acc_len=1) -> correct result.
- Same scenario with clr in place of rst -> same result; ovf previously set is cleared.
